eco32_core_ifu_evm_ffp: RTL and testbench

ECO32_CORE_IFU_EVM_FFP -- requirements
Module: eco32_core_ifu_evm_ffp

---
 rtl/eco32_core_ifu_evm_ffp.sv | 116 +++++++++++
 tb/tb_eco32_core_ifu_evm_ffp.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eco32_core_ifu_evm_ffp.sv
// Show-ahead event FIFO with almost-full/almost-empty flags and sticky over/underflow errors.
// Optional duplicate-push suppression is enabled by defining ECO32_IFU_EVM_DEDUP_EN.
module eco32_core_ifu_evm_ffp #(
   parameter int ERX_W      = 5,
   parameter int EID_W      = 4,
   parameter int DEPTH_LOG2 = 4,
   parameter int AF_LIMIT   = 2,
   parameter int AE_LIMIT   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_stb,
   input  logic [ERX_W-1:0]      i_erx,
   input  logic [EID_W-1:0]      i_eid,
   output logic                  i_af,
   output logic                  i_full,
   output logic                  i_err,
   output logic                  o_stb,
   output logic [ERX_W-1:0]      o_erx,
   output logic [EID_W-1:0]      o_eid,
   input  logic                  o_ack,
   output logic                  o_ae,
   output logic                  o_err,
   output logic [DEPTH_LOG2:0]   o_level,
   input  logic                  err_clr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int PW    = DEPTH_LOG2;
   localparam int KW    = ERX_W + EID_W;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LIMIT);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LIMIT);

   logic [KW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt;
   logic [KW-1:0] din;
   logic          full, empty, dup;
   logic          push_ok, pop_ok, ovf, udf;

   assign din   = {i_erx, i_eid};
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

`ifdef ECO32_IFU_EVM_DEDUP_EN
   // Last accepted entry; only meaningful while the FIFO still holds data.
   logic [KW-1:0] last_q;
   logic          last_vld;

   assign dup = last_vld && (din == last_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         last_vld <= 1'b0;
         last_q   <= '0;
      end else begin
         if (push_ok) begin
            last_q   <= din;
            last_vld <= 1'b1;
         end else if (count_nxt == '0) begin
            last_vld <= 1'b0;
         end
      end
   end
`else
   assign dup = 1'b0;
`endif

   assign push_ok = i_stb && !dup && !full;
   assign ovf     = i_stb && !dup && full;
   assign pop_ok  = o_ack && !empty;
   assign udf     = o_ack && empty;

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         i_err  <= 1'b0;
         o_err  <= 1'b0;
      end else begin
         count <= count_nxt;
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         if (ovf)          i_err <= 1'b1;
         else if (err_clr) i_err <= 1'b0;
         if (udf)          o_err <= 1'b1;
         else if (err_clr) o_err <= 1'b0;
      end
   end

   // NOTE: storage has no reset; the head is only qualified by o_stb, so stale contents are harmless.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   assign o_stb   = !empty;
   assign {o_erx, o_eid} = mem[rd_ptr];
   assign i_full  = full;
   assign i_af    = (DEPTH_C - count) <= AF_C;
   assign o_ae    = count <= AE_C;
   assign o_level = count;

endmodule

// File: tb/tb_eco32_core_ifu_evm_ffp.sv
// Self-checking bench for eco32_core_ifu_evm_ffp: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_eco32_core_ifu_evm_ffp;

   localparam int ERX_W = 5;
   localparam int EID_W = 4;
   localparam int DEPTH = 16;
`ifdef ECO32_IFU_EVM_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             i_stb = 1'b0;
   logic [ERX_W-1:0] i_erx = '0;
   logic [EID_W-1:0] i_eid = '0;
   logic             i_af, i_full, i_err;
   logic             o_stb;
   logic [ERX_W-1:0] o_erx;
   logic [EID_W-1:0] o_eid;
   logic             o_ack = 1'b0;
   logic             o_ae, o_err;
   logic [4:0]       o_level;
   logic             err_clr = 1'b0;

   int tests_run    = 0;
   int tests_failed = 0;

   eco32_core_ifu_evm_ffp dut (
      .clk(clk), .rst(rst),
      .i_stb(i_stb), .i_erx(i_erx), .i_eid(i_eid),
      .i_af(i_af), .i_full(i_full), .i_err(i_err),
      .o_stb(o_stb), .o_erx(o_erx), .o_eid(o_eid), .o_ack(o_ack),
      .o_ae(o_ae), .o_err(o_err), .o_level(o_level), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of {erx,eid} plus sticky flags and the dedup tracker.
   logic [ERX_W+EID_W-1:0] mq[$];
   bit                     m_ierr, m_oerr, m_lvld;
   logic [ERX_W+EID_W-1:0] m_last;

   task automatic model_step(input bit stb, input bit ack, input logic [ERX_W+EID_W-1:0] d,
                             input bit clr, input bit r);
      bit dup, push, pop, ovf, udf;
      if (r) begin
         mq.delete();
         m_ierr = 0; m_oerr = 0; m_lvld = 0;
         return;
      end
      dup  = DEDUP && stb && m_lvld && (d == m_last);
      push = stb && !dup && (mq.size() < DEPTH);
      ovf  = stb && !dup && (mq.size() == DEPTH);
      pop  = ack && (mq.size() != 0);
      udf  = ack && (mq.size() == 0);
      if (pop) void'(mq.pop_front());
      if (push) begin
         mq.push_back(d);
         m_last = d;
         m_lvld = 1;
      end else if (mq.size() == 0) begin
         m_lvld = 0;
      end
      if (ovf) m_ierr = 1; else if (clr) m_ierr = 0;
      if (udf) m_oerr = 1; else if (clr) m_oerr = 0;
   endtask

   // One clock: apply inputs, advance model, sample #1 after the edge, release inputs.
   task automatic cycle(input bit stb, input bit ack, input int erx, input int eid,
                        input bit clr, input bit r);
      i_stb = stb; o_ack = ack; i_erx = ERX_W'(erx); i_eid = EID_W'(eid);
      err_clr = clr; rst = r;
      model_step(stb, ack, {ERX_W'(erx), EID_W'(eid)}, clr, r);
      @(posedge clk);
      #1;
      i_stb = 0; o_ack = 0; err_clr = 0; rst = 0;
   endtask

   task automatic test_reset();
      cycle(1, 1, 7, 7, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      tests_run++;
      if ({o_stb, i_full, i_af, o_ae, o_level, i_err, o_err} !== {1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_state: stb=%b full=%b af=%b ae=%b level=%0d ierr=%b oerr=%b, required 0 0 0 1 0 0 0",
                  o_stb, i_full, i_af, o_ae, o_level, i_err, o_err);
      end
   endtask

   task automatic test_single_push();
      cycle(0, 0, 0, 0, 0, 1);
      cycle(1, 0, 3, 9, 0, 0);
      tests_run++;
      if ({o_stb, o_erx, o_eid, o_level, o_ae} !== {1'b1, 5'd3, 4'd9, 5'd1, 1'b1}) begin
         tests_failed++;
         $display("FAIL single_push: stb=%b erx=%0d eid=%0d level=%0d ae=%b, required 1 3 9 1 1",
                  o_stb, o_erx, o_eid, o_level, o_ae);
      end
      cycle(1, 0, 4, 2, 0, 0);
      tests_run++;
      if ({o_erx, o_eid, o_level, o_ae} !== {5'd3, 4'd9, 5'd2, 1'b0}) begin
         tests_failed++;
         $display("FAIL second_push_head: erx=%0d eid=%0d level=%0d ae=%b, required 3 9 2 0",
                  o_erx, o_eid, o_level, o_ae);
      end
   endtask

   task automatic test_fill_overflow();
      cycle(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 14; i++) begin
         cycle(1, 0, i, i, 0, 0);
         if (i == 12) begin
            tests_run++;
            if (i_af !== 1'b0) begin
               tests_failed++;
               $display("FAIL af_at_13: af=%b, required 0", i_af);
            end
         end
      end
      tests_run++;
      if ({i_af, i_full, o_level} !== {1'b1, 1'b0, 5'd14}) begin
         tests_failed++;
         $display("FAIL af_at_14: af=%b full=%b level=%0d, required 1 0 14", i_af, i_full, o_level);
      end
      cycle(1, 0, 14, 14, 0, 0);
      cycle(1, 0, 15, 15, 0, 0);
      tests_run++;
      if ({i_full, o_level, i_err} !== {1'b1, 5'd16, 1'b0}) begin
         tests_failed++;
         $display("FAIL full_at_16: full=%b level=%0d ierr=%b, required 1 16 0", i_full, o_level, i_err);
      end
      cycle(1, 0, 20, 3, 0, 0);
      tests_run++;
      if ({i_err, o_level, o_erx, o_eid} !== {1'b1, 5'd16, 5'd0, 4'd0}) begin
         tests_failed++;
         $display("FAIL overflow_drop: ierr=%b level=%0d head=%0d/%0d, required 1 16 0/0",
                  i_err, o_level, o_erx, o_eid);
      end
   endtask

   // Continues from a full FIFO with i_err set.
   task automatic test_full_push_pop();
      cycle(0, 0, 0, 0, 1, 0);
      tests_run++;
      if (i_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL ierr_clear: ierr=%b, required 0", i_err);
      end
      cycle(1, 1, 21, 5, 0, 0);
      tests_run++;
      if ({i_err, o_level, i_full, o_erx, o_eid} !== {1'b1, 5'd15, 1'b0, 5'd1, 4'd1}) begin
         tests_failed++;
         $display("FAIL full_push_pop: ierr=%b level=%0d full=%b head=%0d/%0d, required 1 15 0 1/1",
                  i_err, o_level, i_full, o_erx, o_eid);
      end
      cycle(0, 0, 0, 0, 1, 0);
      cycle(1, 0, 22, 6, 0, 0);
      cycle(1, 0, 23, 7, 1, 0);
      tests_run++;
      if ({i_err, o_level} !== {1'b1, 5'd16}) begin
         tests_failed++;
         $display("FAIL set_wins_clr: ierr=%b level=%0d, required 1 16", i_err, o_level);
      end
      for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, 0, 0);
      tests_run++;
      if ({o_stb, o_level, o_err} !== {1'b0, 5'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL drain: stb=%b level=%0d oerr=%b, required 0 0 0", o_stb, o_level, o_err);
      end
   endtask

   task automatic test_underflow();
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 1, 0, 0, 0, 0);
      tests_run++;
      if ({o_err, o_level, o_stb} !== {1'b1, 5'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL underflow: oerr=%b level=%0d stb=%b, required 1 0 0", o_err, o_level, o_stb);
      end
      cycle(0, 0, 0, 0, 0, 0);
      tests_run++;
      if (o_err !== 1'b1) begin
         tests_failed++;
         $display("FAIL oerr_sticky: oerr=%b, required 1", o_err);
      end
      cycle(0, 0, 0, 0, 1, 0);
      tests_run++;
      if (o_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL oerr_clear: oerr=%b, required 0", o_err);
      end
   endtask

   task automatic test_wrap();
      int bad = 0;
      cycle(0, 0, 0, 0, 0, 1);
      cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         if (o_eid !== EID_W'(i % 16) || o_stb !== 1'b1) bad++;
         cycle(1, 1, 0, (i + 1) % 16, 0, 0);
         if (o_level !== 5'd1) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL wrap_order: %0d mismatched cycles, required 0", bad);
      end
      cycle(1, 1, 0, 9, 0, 1);
      tests_run++;
      if ({o_stb, o_level} !== {1'b0, 5'd0}) begin
         tests_failed++;
         $display("FAIL midstream_reset: stb=%b level=%0d, required 0 0", o_stb, o_level);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      cycle(0, 0, 0, 0, 0, 1);
      for (int n = 0; n < 600; n++) begin
         bit stb, ack, clr, r;
         int phase = (n / 100) % 2;
         stb = phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         ack = phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         r   = ($urandom_range(0, 127) == 0);
         cycle(stb, ack, $urandom_range(0, 1), $urandom_range(0, 2), clr, r);
         if (o_level !== 5'(mq.size()) || o_stb !== (mq.size() != 0) ||
             i_full !== (mq.size() == DEPTH) || i_af !== (DEPTH - mq.size() <= 2) ||
             o_ae !== (mq.size() <= 1) || i_err !== m_ierr || o_err !== m_oerr ||
             (mq.size() != 0 && {o_erx, o_eid} !== mq[0])) begin
            bad++;
            if (bad <= 5)
               $display("FAIL random_cycle_%0d: level=%0d stb=%b full=%b af=%b ae=%b ierr=%b oerr=%b head=%h, required level=%0d ierr=%b oerr=%b",
                        n, o_level, o_stb, i_full, i_af, o_ae, i_err, o_err, {o_erx, o_eid},
                        mq.size(), m_ierr, m_oerr);
         end
      end
      tests_run++;
      if (bad != 0) tests_failed++;
   endtask

`ifdef ECO32_IFU_EVM_DEDUP_EN
   task automatic test_dedup();
      cycle(0, 0, 0, 0, 0, 1);
      cycle(1, 0, 1, 5, 0, 0);
      cycle(1, 0, 1, 5, 0, 0);
      cycle(1, 0, 1, 6, 0, 0);
      tests_run++;
      if (o_level !== 5'd2) begin
         tests_failed++;
         $display("FAIL dedup_level: level=%0d, required 2", o_level);
      end
      cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);
      cycle(1, 0, 1, 6, 0, 0);
      tests_run++;
      if ({o_level, o_erx, o_eid} !== {5'd1, 5'd1, 4'd6}) begin
         tests_failed++;
         $display("FAIL dedup_after_drain: level=%0d head=%0d/%0d, required 1 1/6", o_level, o_erx, o_eid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_push();
      test_fill_overflow();
      test_full_push_pop();
      test_underflow();
      test_wrap();
`ifdef ECO32_IFU_EVM_DEDUP_EN
      test_dedup();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
